// File: rtl/framhd_pkg.sv
// Shared definitions for the frame-head protection block: per-channel state
// codes and the circular-distance helper used for the acceptance window.
package framhd_pkg;

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_LOCK    = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    // Distance between two linear positions on a ring of 'period' slots,
    // taking the shorter way round so heads across the wrap point are close.
    function automatic logic [31:0] circ_dist(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] period);
        logic [31:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        circ_dist = (d > (period - d)) ? (period - d) : d;
    endfunction

endpackage

// File: rtl/framhd_protect_mc_if.sv
// Bundle of the per-channel frame-head signals plus the shared position, as
// seen by whoever drives the heads (master) and by the protector (slave).
interface framhd_protect_mc_if #(
    parameter int NUM_CH = 4,
    parameter int POS_W  = 23
);
    logic [NUM_CH-1:0]   ext_hd;
    logic [NUM_CH-1:0]   ch_en;
    logic [NUM_CH-1:0]   int_hd;
    logic [NUM_CH-1:0]   lock;
    logic [2*NUM_CH-1:0] state;
    logic [POS_W-1:0]    pos;

    modport master (
        output ext_hd, ch_en,
        input  int_hd, lock, state, pos
    );

    modport slave (
        input  ext_hd, ch_en,
        output int_hd, lock, state, pos
    );
endinterface

// File: rtl/framhd_ch_track.sv
// One frame-head tracking channel: hunts for a head, confirms it, then locks and
// regenerates heads from the frozen reference, riding through missing heads.
module framhd_ch_track
    import framhd_pkg::*;
#(
    parameter int LIN_W      = 5,
    parameter int PERIOD     = 20,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             asy_rst,
    input  logic [LIN_W-1:0] i_lin,
    input  logic             i_ext_hd,
    input  logic             i_ch_en,
    output logic             o_int_hd,
    output logic             o_lock,
    output logic [1:0]       o_state
);

    localparam int HIT_W  = $clog2(LOCK_CNT) + 1;
    localparam int MISS_W = $clog2(UNLOCK_CNT) + 1;
    localparam logic [HIT_W-1:0]  HIT_ONE  = HIT_W'(1);
    localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

    logic [1:0]        state_q,   state_d;
    logic [LIN_W-1:0]  ref_q,     ref_d;
    logic [HIT_W-1:0]  hit_q,     hit_d;
    logic [MISS_W-1:0] miss_q,    miss_d;
    logic              win_hit_q, win_hit_d;
    logic              int_hd_q,  int_hd_d;

    logic              in_win;
    logic              at_close;
    logic              head_ok;
    logic              hit_reach;
    logic              miss_reach;
    logic [31:0]       close_sum;
    logic [HIT_W-1:0]  hit_inc;
    logic [MISS_W-1:0] miss_inc;

    // Window bookkeeping: win_hit_q remembers that the current window already
    // took its one head; it is cleared at the window's closing slot.
    always_comb begin
        close_sum = 32'(ref_q) + 32'(TOL);
        if (close_sum >= 32'(PERIOD)) begin
            close_sum = close_sum - 32'(PERIOD);
        end
        at_close   = (i_lin == LIN_W'(close_sum));
        in_win     = circ_dist(32'(i_lin), 32'(ref_q), 32'(PERIOD)) <= 32'(TOL);
        head_ok    = i_ext_hd && in_win && !win_hit_q;
        hit_inc    = (&hit_q)  ? hit_q  : hit_q + HIT_ONE;
        miss_inc   = (&miss_q) ? miss_q : miss_q + MISS_ONE;
        hit_reach  = (32'(hit_q) + 32'd1) >= 32'(LOCK_CNT);
        miss_reach = (32'(miss_q) + 32'd1) >= 32'(UNLOCK_CNT);
    end

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        win_hit_d = win_hit_q;
        int_hd_d  = i_ch_en && (state_q == ST_LOCK || state_q == ST_HOLD) && (i_lin == ref_q);

        case (state_q)
            ST_HUNT: begin
                if (i_ext_hd) begin
                    ref_d     = i_lin;
                    hit_d     = HIT_ONE;
                    win_hit_d = 1'b1;
                    state_d   = ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                // Re-centring on every accepted head moves the window with it,
                // so a head takes priority over the old window's close.
                if (head_ok) begin
                    ref_d     = i_lin;
                    hit_d     = hit_inc;
                    win_hit_d = 1'b1;
                    if (hit_reach) begin
                        state_d = ST_LOCK;
                    end
                end else if (i_ext_hd && !in_win) begin
                    ref_d     = i_lin;
                    hit_d     = HIT_ONE;
                    win_hit_d = 1'b1;
                end else if (at_close) begin
                    win_hit_d = 1'b0;
                    if (!win_hit_q) begin
                        state_d = ST_HUNT;
                        hit_d   = '0;
                    end
                end
            end
            ST_LOCK: begin
                if (at_close) begin
                    win_hit_d = 1'b0;
                    if (win_hit_q || head_ok) begin
                        miss_d = '0;
                    end else begin
                        miss_d  = miss_inc;
                        state_d = ST_HOLD;
                    end
                end else if (head_ok) begin
                    miss_d    = '0;
                    win_hit_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (head_ok) begin
                    miss_d    = '0;
                    win_hit_d = !at_close;
                    state_d   = ST_LOCK;
                end else if (at_close) begin
                    win_hit_d = 1'b0;
                    miss_d    = miss_inc;
                    if (miss_reach) begin
                        state_d = ST_HUNT;
                        hit_d   = '0;
                        miss_d  = '0;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        if (!i_ch_en) begin
            state_d   = ST_HUNT;
            hit_d     = '0;
            miss_d    = '0;
            win_hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            state_q   <= ST_HUNT;
            ref_q     <= '0;
            hit_q     <= '0;
            miss_q    <= '0;
            win_hit_q <= 1'b0;
            int_hd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            win_hit_q <= win_hit_d;
            int_hd_q  <= int_hd_d;
        end
    end

    assign o_int_hd = int_hd_q;
    assign o_lock   = (state_q == ST_LOCK) || (state_q == ST_HOLD);
    assign o_state  = state_q;

endmodule

// File: rtl/framhd_protect_mc.sv
// Multi-channel frame-head protector: one shared {int,dec} position counter
// feeding NUM_CH independent tracking channels.
module framhd_protect_mc
    import framhd_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DEC_W      = 8,
    parameter int INT_W      = 15,
    parameter int DEC_MAX    = 149,
    parameter int INT_MAX    = 16383,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                   asy_rst,
    input  logic                   clk,
    input  logic [NUM_CH-1:0]      i_ext_hd,
    input  logic [NUM_CH-1:0]      i_ch_en,
    output logic [NUM_CH-1:0]      o_int_hd,
    output logic [NUM_CH-1:0]      o_lock,
    output logic [2*NUM_CH-1:0]    o_state,
    output logic [INT_W+DEC_W-1:0] o_pos
);

    localparam int PERIOD = (INT_MAX + 1) * (DEC_MAX + 1);
    localparam int LIN_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [DEC_W-1:0] dec_q,   dec_d;
    logic [INT_W-1:0] ipart_q, ipart_d;
    logic [LIN_W-1:0] lin_q,   lin_d;

    // lin_q runs alongside {int,dec} as a flat 0..PERIOD-1 index so the
    // channels can do window arithmetic without a multiply.
    always_comb begin
        dec_d   = dec_q + DEC_W'(1);
        ipart_d = ipart_q;
        lin_d   = lin_q + LIN_W'(1);
        if (dec_q == DEC_W'(DEC_MAX)) begin
            dec_d = '0;
            if (ipart_q == INT_W'(INT_MAX)) begin
                ipart_d = '0;
            end else begin
                ipart_d = ipart_q + INT_W'(1);
            end
        end
        if (lin_q == LIN_W'(PERIOD - 1)) begin
            lin_d = '0;
        end
    end

    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            dec_q   <= '0;
            ipart_q <= '0;
            lin_q   <= '0;
        end else begin
            dec_q   <= dec_d;
            ipart_q <= ipart_d;
            lin_q   <= lin_d;
        end
    end

    assign o_pos = {ipart_q, dec_q};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        framhd_ch_track #(
            .LIN_W      (LIN_W),
            .PERIOD     (PERIOD),
            .TOL        (TOL),
            .LOCK_CNT   (LOCK_CNT),
            .UNLOCK_CNT (UNLOCK_CNT)
        ) u_track (
            .clk      (clk),
            .asy_rst  (asy_rst),
            .i_lin    (lin_q),
            .i_ext_hd (i_ext_hd[g]),
            .i_ch_en  (i_ch_en[g]),
            .o_int_hd (o_int_hd[g]),
            .o_lock   (o_lock[g]),
            .o_state  (o_state[2*g +: 2])
        );
    end

endmodule

// File: tb/tb_framhd_protect_mc.sv
// Directed bench for framhd_protect_mc on a 20-slot ring (DEC_MAX=3, INT_MAX=4),
// where o_pos equals the flat slot index because DEC_MAX+1 is a power of two.
module tb_framhd_protect_mc;

    localparam int NUM_CH     = 2;
    localparam int DEC_W      = 2;
    localparam int INT_W      = 3;
    localparam int DEC_MAX    = 3;
    localparam int INT_MAX    = 4;
    localparam int TOL        = 1;
    localparam int LOCK_CNT   = 3;
    localparam int UNLOCK_CNT = 2;
    localparam int POS_W      = INT_W + DEC_W;
    localparam int PERIOD     = 20;

    logic clk = 1'b0;
    logic asy_rst;
    int   n_vec = 0;
    int   n_err = 0;

    framhd_protect_mc_if #(.NUM_CH(NUM_CH), .POS_W(POS_W)) bus ();

    framhd_protect_mc #(
        .NUM_CH     (NUM_CH),
        .DEC_W      (DEC_W),
        .INT_W      (INT_W),
        .DEC_MAX    (DEC_MAX),
        .INT_MAX    (INT_MAX),
        .TOL        (TOL),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) dut (
        .asy_rst  (asy_rst),
        .clk      (clk),
        .i_ext_hd (bus.ext_hd),
        .i_ch_en  (bus.ch_en),
        .o_int_hd (bus.int_hd),
        .o_lock   (bus.lock),
        .o_state  (bus.state),
        .o_pos    (bus.pos)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Always advances at least one clock, then stops when o_pos reads p.
    task automatic wait_pos(input int p);
        int budget;
        budget = 0;
        step();
        while (int'(bus.pos) != p && budget < 2 * PERIOD + 2) begin
            step();
            budget++;
        end
        if (int'(bus.pos) != p) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_pos: o_pos %0d never reached %0d", bus.pos, p);
        end
    endtask

    task automatic head_at(input int ch, input int p);
        wait_pos(p);
        bus.ext_hd[ch] = 1'b1;
        step();
        bus.ext_hd[ch] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ext_hd = '0;
        bus.ch_en  = '1;
        asy_rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",  bus.state,  4'b0000);
        chk("rst_lock",   bus.lock,   2'b00);
        chk("rst_int_hd", bus.int_hd, 2'b00);
        chk("rst_pos",    bus.pos,    5'd0);
        @(negedge clk);
        asy_rst = 1'b0;

        // Heads at slot 7 every period: confirm, then lock on the third.
        head_at(0, 7);
        chk("acq1_state", bus.state, 4'b0001);
        head_at(0, 7);
        chk("acq2_state", bus.state, 4'b0001);
        head_at(0, 7);
        chk("acq3_state",  bus.state,  4'b0010);
        chk("acq3_lock",   bus.lock,   2'b01);
        chk("acq3_int_hd", bus.int_hd, 2'b00);
        head_at(0, 7);
        chk("lock_pulse",  bus.int_hd, 2'b01);
        step();
        chk("pulse_width", bus.int_hd, 2'b00);

        // Head one slot late is in-window but must not move the reference.
        head_at(0, 8);
        chk("late_state", bus.state, 4'b0010);
        head_at(0, 7);
        chk("ref_frozen_pulse", bus.int_hd, 2'b01);
        head_at(0, 10);
        chk("oow_ignored_state", bus.state, 4'b0010);
        head_at(0, 10);
        chk("hold_state", bus.state, 4'b0011);
        chk("hold_lock",  bus.lock,  2'b01);
        head_at(0, 7);
        chk("hold_pulse",    bus.int_hd, 2'b01);
        chk("relock_state",  bus.state,  4'b0010);

        // Heads stop: HOLD after one empty window, HUNT after the second.
        wait_pos(8);
        chk("miss1_pulse", bus.int_hd, 2'b01);
        step();
        chk("miss1_state", bus.state, 4'b0011);
        wait_pos(8);
        chk("miss2_pulse", bus.int_hd, 2'b01);
        step();
        chk("miss2_state", bus.state, 4'b0000);
        chk("miss2_lock",  bus.lock,  2'b00);
        wait_pos(8);
        chk("hunt_no_pulse", bus.int_hd, 2'b00);

        // Reference 0 with heads at slot 19: accepted across the wrap.
        head_at(0, 0);
        chk("wrap1_state", bus.state, 4'b0001);
        head_at(0, 19);
        chk("wrap2_state", bus.state, 4'b0001);
        head_at(0, 19);
        chk("wrap3_state", bus.state, 4'b0010);
        head_at(0, 19);
        chk("wrap_pulse", bus.int_hd, 2'b01);

        // Lock channel 1 at slot 3 while channel 0 keeps its heads at 19.
        for (int i = 0; i < 3; i++) begin
            head_at(1, 3);
            head_at(0, 19);
        end
        chk("dual_state", bus.state, 4'b1010);
        chk("dual_lock",  bus.lock,  2'b11);
        wait_pos(4);
        chk("ch1_pulse", bus.int_hd, 2'b10);
        bus.ch_en[1] = 1'b0;
        step();
        bus.ch_en[1] = 1'b1;
        chk("dis_state", bus.state, 4'b0010);
        chk("dis_lock",  bus.lock,  2'b01);
        head_at(0, 19);
        chk("dis_ch0_pulse", bus.int_hd, 2'b01);

        // Asynchronous reset while channel 0 is mid-pulse.
        asy_rst = 1'b1;
        #1;
        chk("arst_state",  bus.state,  4'b0000);
        chk("arst_lock",   bus.lock,   2'b00);
        chk("arst_int_hd", bus.int_hd, 2'b00);
        chk("arst_pos",    bus.pos,    5'd0);
        @(negedge clk);
        asy_rst = 1'b0;
        head_at(0, 7);
        head_at(0, 7);
        chk("post_rst2_state", bus.state, 4'b0001);
        head_at(0, 7);
        chk("post_rst3_state", bus.state, 4'b0010);
        chk("post_rst3_lock",  bus.lock,  2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
